// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a valid/ready handshake on both sides.
// Single-cycle ops finish one cycle after acceptance; with SEQ_ALU_MULDIV_EN
// defined, MUL/MULHU/DIVU/REMU iterate one bit per cycle for WIDTH cycles.
// Without SEQ_ALU_MULDIV_EN, opcodes 1010-1101 return inp1 in one cycle.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_flag
);

  localparam int SHAMT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t r_state, w_next;

  logic               w_accept;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_alu;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign w_accept   = in_valid & in_ready;
  assign w_shamt    = inp2[SHAMT_W-1:0];
  assign alu_result = r_result;
  assign zero_flag  = r_zero;

`ifdef SEQ_ALU_MULDIV_EN
  // Iterative datapath: r_acc holds {hi, lo}. For MUL, lo starts as the
  // multiplier and shifts out LSB-first while partial sums enter hi. For
  // DIVU, lo starts as the dividend and becomes the quotient while hi is the
  // running remainder. Divide by zero needs no special case: every trial
  // subtraction succeeds (quotient all ones) and the remainder ends as inp1.
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_is_div;
  logic               r_hi;
  logic [SHAMT_W-1:0] r_cnt;
  logic [2*WIDTH-1:0] r_acc;

  logic               w_is_iter;
  logic               w_last;
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH:0]     w_rsh;
  logic [WIDTH-1:0]   w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_div_nxt;
  logic [2*WIDTH-1:0] w_it_nxt;
  logic [WIDTH-1:0]   w_it_res;

  assign w_is_iter = alu_control inside {[4'b1010:4'b1101]};
  assign w_last    = &r_cnt;

  assign w_msum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mul_nxt = {w_msum, r_acc[WIDTH-1:1]};

  // Remainder is always below the divisor (when nonzero), so the W-bit
  // difference is exact whenever the trial subtraction succeeds.
  assign w_rsh     = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge      = (w_rsh >= {1'b0, r_b});
  assign w_diff    = w_rsh[WIDTH-1:0] - r_b;
  assign w_div_nxt = {(w_ge ? w_diff : w_rsh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

  assign w_it_nxt  = r_is_div ? w_div_nxt : w_mul_nxt;
  assign w_it_res  = r_hi ? w_it_nxt[2*WIDTH-1:WIDTH] : w_it_nxt[WIDTH-1:0];
`endif

  // Single-cycle result, computed straight from the accepted inputs.
  always_comb begin
    w_alu = inp1;
    case (alu_control)
      4'b0000: w_alu = inp1 + inp2;
      4'b0001: w_alu = inp1 - inp2;
      4'b0010: w_alu = inp1 & inp2;
      4'b0011: w_alu = inp1 | inp2;
      4'b0100: w_alu = inp1 ^ inp2;
      4'b0101: w_alu = inp1 << w_shamt;
      4'b0110: w_alu = inp1 >> w_shamt;
      4'b0111: w_alu = $signed(inp1) >>> w_shamt;
      4'b1000: w_alu = {{(WIDTH-1){1'b0}}, ($signed(inp1) < $signed(inp2))};
      4'b1001: w_alu = {{(WIDTH-1){1'b0}}, (inp1 < inp2)};
      default: w_alu = inp1;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // FSM next-state: accept in IDLE, iterate in BUSY, hold in DONE until taken.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
`ifdef SEQ_ALU_MULDIV_EN
        if (in_valid) w_next = w_is_iter ? BUSY : DONE;
`else
        if (in_valid) w_next = DONE;
`endif
      end
`ifdef SEQ_ALU_MULDIV_EN
      BUSY:    if (w_last) w_next = DONE;
`endif
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Result/flag registers plus operand capture and iteration state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_zero   <= 1'b1;
`ifdef SEQ_ALU_MULDIV_EN
      r_a      <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_hi     <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
`endif
    end else begin
`ifdef SEQ_ALU_MULDIV_EN
      if (w_accept && w_is_iter) begin
        r_a      <= inp1;
        r_b      <= inp2;
        r_is_div <= alu_control[2];
        r_hi     <= alu_control[0];
        r_cnt    <= '0;
        r_acc    <= {{WIDTH{1'b0}}, (alu_control[2] ? inp1 : inp2)};
      end else if (w_accept) begin
        r_result <= w_alu;
        r_zero   <= (w_alu == '0);
      end
      if (r_state == BUSY) begin
        r_acc <= w_it_nxt;
        r_cnt <= r_cnt + SHAMT_W'(1);
        if (w_last) begin
          r_result <= w_it_res;
          r_zero   <= (w_it_res == '0);
        end
      end
`else
      if (w_accept) begin
        r_result <= w_alu;
        r_zero   <= (w_alu == '0);
      end
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed literal cases plus
// randomized operations, all checked every cycle against a transaction-level
// model (pending op, its age, required latency, expected result).
module tb_seq_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] inp1;
  logic [W-1:0] inp2;
  logic [3:0]   alu_control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_result;
  logic         zero_flag;

  int n_tests = 0;
  int n_fail  = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inp1(inp1), .inp2(inp2), .alu_control(alu_control),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .zero_flag(zero_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail < 30) $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference result from the opcode table.
  function automatic logic [W-1:0] ref_res(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0]      p;
    logic signed [W-1:0] sa;
    int                  sh;
    sh = int'(b[4:0]);
    sa = a;
    p  = {32'b0, a} * {32'b0, b};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return sa >>> sh;
      4'd8:  return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd9:  return (a < b) ? 1 : 0;
`ifdef SEQ_ALU_MULDIV_EN
      4'd10: return p[W-1:0];
      4'd11: return p[2*W-1:W];
      4'd12: return (b == 0) ? '1 : a / b;
      4'd13: return (b == 0) ? a : a % b;
`endif
      default: return a;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
`ifdef SEQ_ALU_MULDIV_EN
    if (op >= 4'd10 && op <= 4'd13) return W + 1;
`endif
    return 1;
  endfunction

  // Transaction model: one op in flight at most, done once its age reaches
  // the required latency, retired when out_ready is seen while done.
  bit           m_pend = 0;
  int           m_age  = 0;
  int           m_lat  = 1;
  logic [W-1:0] m_res  = '0;
  logic [W-1:0] m_last = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_pend = 0;
      m_last = '0;
    end else if (!m_pend) begin
      if (in_valid) begin
        m_pend = 1;
        m_age  = 1;
        m_lat  = ref_lat(alu_control);
        m_res  = ref_res(alu_control, inp1, inp2);
      end
    end else if (m_age >= m_lat) begin
      if (out_ready) begin
        m_pend = 0;
        m_last = m_res;
      end
    end else begin
      m_age++;
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    logic         ev;
    logic [W-1:0] er;
    ev = m_pend && (m_age >= m_lat);
    er = ev ? m_res : m_last;
    chk("in_ready",   {31'b0, in_ready},  {31'b0, !m_pend});
    chk("out_valid",  {31'b0, out_valid}, {31'b0, ev});
    chk("alu_result", alu_result, er);
    chk("zero_flag",  {31'b0, zero_flag}, {31'b0, (er == '0)});
  end

  // Issue one op at a negedge with the DUT idle; returns result and latency.
  // Inputs are scrambled after acceptance and in_valid toggles while DONE.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, output logic [W-1:0] res, output logic z, output int lat);
    in_valid = 1'b1; alu_control = op; inp1 = a; inp2 = b; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; inp1 = $urandom; inp2 = $urandom; alu_control = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: out_valid not seen within %0d cycles, required %0d", lat, ref_lat(op));
    end
    res = alu_result;
    z   = zero_flag;
    repeat (hold) begin
      in_valid = 1'($urandom);
      @(negedge clk);
    end
    if (hold > 0) chk("hold_stable", alu_result, res);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  logic [W-1:0] r;
  logic         z;
  int           lat;

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    inp1 = '0; inp2 = '0; alu_control = '0;
    repeat (3) @(negedge clk);
    chk("reset_result", alu_result, '0);
    chk("reset_zero",   {31'b0, zero_flag}, 32'd1);
    chk("reset_valid",  {31'b0, out_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'b0, in_ready}, 32'd1);

    do_op(4'd0, 32'hFFFF_FFFF, 32'd1, 0, r, z, lat);
    chk("add_wrap", r, 32'd0);
    chk("add_zero", {31'b0, z}, 32'd1);
    chk("add_lat", lat, 1);
    do_op(4'd7, 32'h8000_0000, 32'h24, 0, r, z, lat);
    chk("sra", r, 32'hF800_0000);
    do_op(4'd6, 32'h8000_0000, 32'h24, 0, r, z, lat);
    chk("srl", r, 32'h0800_0000);
    do_op(4'd5, 32'h0000_0003, 32'hFFFF_FFFF, 0, r, z, lat);
    chk("sll31", r, 32'h8000_0000);
    do_op(4'd8, 32'hFFFF_FFFF, 32'd1, 0, r, z, lat);
    chk("slt", r, 32'd1);
    do_op(4'd9, 32'hFFFF_FFFF, 32'd1, 0, r, z, lat);
    chk("sltu", r, 32'd0);
    do_op(4'd1, 32'd5, 32'd7, 0, r, z, lat);
    chk("sub_wrap", r, 32'hFFFF_FFFE);

`ifdef SEQ_ALU_MULDIV_EN
    do_op(4'd10, 32'h1_0000, 32'h1_0000, 0, r, z, lat);
    chk("mul_lo", r, 32'd0);
    chk("mul_zero", {31'b0, z}, 32'd1);
    chk("mul_lat", lat, 33);
    do_op(4'd11, 32'h1_0000, 32'h1_0000, 0, r, z, lat);
    chk("mulhu", r, 32'd1);
    do_op(4'd12, 32'd100, 32'd7, 0, r, z, lat);
    chk("divu", r, 32'd14);
    chk("divu_lat", lat, 33);
    do_op(4'd13, 32'd100, 32'd7, 0, r, z, lat);
    chk("remu", r, 32'd2);
    do_op(4'd12, 32'd5, 32'd0, 0, r, z, lat);
    chk("divu_by0", r, 32'hFFFF_FFFF);
    chk("divu_by0_lat", lat, 33);
    do_op(4'd13, 32'd5, 32'd0, 0, r, z, lat);
    chk("remu_by0", r, 32'd5);
`else
    do_op(4'd10, 32'd3, 32'd4, 0, r, z, lat);
    chk("mul_passthru", r, 32'd3);
    chk("mul_passthru_lat", lat, 1);
    do_op(4'd12, 32'd100, 32'd7, 0, r, z, lat);
    chk("divu_passthru", r, 32'd100);
`endif
    do_op(4'd15, 32'h1234_5678, 32'd9, 0, r, z, lat);
    chk("op15", r, 32'h1234_5678);

    // Result held with out_ready low for 10 cycles in DONE.
    do_op(4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 10, r, z, lat);
    chk("xor_hold", r, 32'hFF00_FF00);

    // Reset ten cycles into a DIVU: no result may follow it.
    in_valid = 1'b1; alu_control = 4'd12; inp1 = 32'd1000; inp2 = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", {31'b0, in_ready}, 32'd1);
    begin
      bit seen = 0;
      repeat (40) begin
        if (out_valid) seen = 1;
        @(negedge clk);
      end
      chk("no_valid_after_abort", {31'b0, seen}, 32'd0);
    end

    // Randomized operations; the every-cycle compare does the checking.
    repeat (250) begin
      do_op(4'($urandom_range(0, 15)), pick(), pick(), $urandom_range(0, 3), r, z, lat);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
